num_pager: RTL



---
 rtl/num_pager.sv | 122 ++++++++++++
 1 files changed

// File: rtl/num_pager.sv
// Two-digit hex pager for a 32-bit word: debounced buttons pick the byte,
// an optional auto-scroll timer steps through the four bytes.
module num_pager #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int SCROLL_CYCLES   = 50000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] num_data,
  input  logic        btn_next,
  input  logic        btn_mode,
  output logic [7:0]  dpy0,
  output logic [7:0]  dpy1,
  output logic [1:0]  page,
  output logic        auto_mode
);

  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int SW = $clog2(SCROLL_CYCLES);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [SW-1:0] SCROLL_LAST = SW'(SCROLL_CYCLES - 1);

  // Index 0 is btn_next, index 1 is btn_mode.
  logic [1:0]    raw;
  logic [1:0]    sync_a;
  logic [1:0]    sync_b;
  logic [1:0]    stable;
  logic [1:0]    press;
  logic [DW-1:0] deb_cnt [2];

  logic          next_press;
  logic          mode_press;
  logic          expire;
  logic [SW-1:0] timer;

  logic [7:0]    sel_byte;
  logic [7:0]    hi_seg;
  logic [7:0]    lo_seg;

  function automatic logic [7:0] font(input logic [3:0] n);
    case (n)
      4'h0: font = 8'hFC;
      4'h1: font = 8'h60;
      4'h2: font = 8'hDA;
      4'h3: font = 8'hF2;
      4'h4: font = 8'h66;
      4'h5: font = 8'hB6;
      4'h6: font = 8'hBE;
      4'h7: font = 8'hE0;
      4'h8: font = 8'hFE;
      4'h9: font = 8'hF6;
      4'hA: font = 8'hEE;
      4'hB: font = 8'h3E;
      4'hC: font = 8'h9C;
      4'hD: font = 8'h7A;
      4'hE: font = 8'h9E;
      default: font = 8'h8E;
    endcase
  endfunction

  assign raw = {btn_mode, btn_next};

  // The press pulse is raised on the same edge the stable value rises.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_a <= '0;
      sync_b <= '0;
      stable <= '0;
      press  <= '0;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      sync_a <= raw;
      sync_b <= sync_a;
      press  <= '0;
      for (int i = 0; i < 2; i++) begin
        if (sync_b[i] == stable[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          stable[i]  <= ~stable[i];
          press[i]   <= ~stable[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  assign next_press = press[0];
  assign mode_press = press[1];
  assign expire     = auto_mode && (timer == SCROLL_LAST);

  // A mode press suppresses a coinciding expiry; a next press merges with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      page      <= '0;
      auto_mode <= 1'b0;
      timer     <= '0;
    end else begin
      if (next_press || (expire && !mode_press)) page <= page + 2'd1;
      if (mode_press) auto_mode <= ~auto_mode;
      if (!auto_mode || next_press || mode_press || expire) timer <= '0;
      else timer <= timer + SW'(1);
    end
  end

  assign sel_byte = num_data[{page, 3'b000} +: 8];
  assign hi_seg   = font(sel_byte[7:4]);
  assign lo_seg   = font(sel_byte[3:0]);

  // Font entries carry dp=0, so OR-ing in the page bit sets the decimal point.
  always_ff @(posedge clk) begin
    if (reset) begin
      dpy0 <= '0;
      dpy1 <= '0;
    end else begin
      dpy1 <= hi_seg | {7'd0, page[1]};
      dpy0 <= lo_seg | {7'd0, page[0]};
    end
  end

endmodule
